// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_unit
//  Description : Iterative RV32M multiply/divide execute unit. Radix-2
//                shift-add multiply and restoring divide, one bit per cycle,
//                with single-cycle fast paths for divide-by-zero and signed
//                overflow. Each op ends in a one-cycle result beat.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_addr,
  input  logic            flush,
  output logic            busy,
  output logic            res_valid,
  output logic [XLEN-1:0] res_data,
  output logic [4:0]      res_rd
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] c_LAST_ITER = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  c_MIN_INT   = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0]  c_ALL_ONES  = {XLEN{1'b1}};
  localparam logic [XLEN-1:0]  c_ZERO      = {XLEN{1'b0}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  // Latched operation context
  logic [2:0]        r_f3;
  logic [4:0]        r_rd;
  logic [XLEN-1:0]   r_b;
  logic              r_neg;
  logic [CNT_W-1:0]  r_cnt;
  // Shared work register: {hi, lo} = product for multiply, {rem, quo} for divide
  logic [2*XLEN-1:0] r_prod;

  logic              r_busy;
  logic              r_res_valid;
  logic [XLEN-1:0]   r_res_data;
  logic [4:0]        r_res_rd;

  // Operand decode
  logic              w_a_signed;
  logic              w_b_signed;
  logic              w_sign_a;
  logic              w_sign_b;
  logic              w_neg;
  logic [XLEN-1:0]   w_mag_a;
  logic [XLEN-1:0]   w_mag_b;
  logic              w_div_zero;
  logic              w_div_ovf;
  logic              w_fast;
  logic              w_accept;

  // Iteration and result datapath
  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_mul_step;
  logic [XLEN:0]     w_trial;
  logic [2*XLEN-1:0] w_div_step;
  logic [2*XLEN-1:0] w_full;
  logic [XLEN-1:0]   w_qr;
  logic [XLEN-1:0]   w_qr_signed;
  logic [XLEN-1:0]   w_result;

  // Decode operand signedness and form magnitudes plus the result sign
  always_comb begin
    w_a_signed = 1'b0;
    w_b_signed = 1'b0;
    case (funct3)
      3'b001:         begin w_a_signed = 1'b1; w_b_signed = 1'b1; end // MULH
      3'b010:         begin w_a_signed = 1'b1; w_b_signed = 1'b0; end // MULHSU
      3'b100, 3'b110: begin w_a_signed = 1'b1; w_b_signed = 1'b1; end // DIV, REM
      default:        begin w_a_signed = 1'b0; w_b_signed = 1'b0; end
    endcase
    w_sign_a = w_a_signed & rs1_data[XLEN-1];
    w_sign_b = w_b_signed & rs2_data[XLEN-1];
    w_mag_a  = w_sign_a ? (c_ZERO - rs1_data) : rs1_data;
    w_mag_b  = w_sign_b ? (c_ZERO - rs2_data) : rs2_data;
    // Remainder takes the dividend's sign; everything else is sign(A) ^ sign(B)
    w_neg    = (funct3[2] & funct3[1]) ? w_sign_a : (w_sign_a ^ w_sign_b);
    w_div_zero = funct3[2] & (rs2_data == c_ZERO);
    w_div_ovf  = funct3[2] & ~funct3[0] & (rs1_data == c_MIN_INT) &
                 (rs2_data == c_ALL_ONES);
    w_fast     = w_div_zero | w_div_ovf;
    w_accept   = start & ~flush;
  end

  // One multiply step, one divide step, and the final sign-corrected result
  always_comb begin
    // Shift-add: add multiplicand into the high half when the current
    // multiplier bit (lo[0]) is set, then shift the whole pair right.
    w_mul_sum  = {1'b0, r_prod[2*XLEN-1:XLEN]} +
                 (r_prod[0] ? {1'b0, r_b} : {(XLEN+1){1'b0}});
    w_mul_step = {w_mul_sum, r_prod[XLEN-1:1]};
    // Restoring divide: shift the next dividend bit into the remainder and
    // keep the subtraction only if it did not borrow.
    w_trial    = {r_prod[2*XLEN-1:XLEN], r_prod[XLEN-1]} - {1'b0, r_b};
    w_div_step = w_trial[XLEN] ? {r_prod[2*XLEN-2:0], 1'b0}
                               : {w_trial[XLEN-1:0], r_prod[XLEN-2:0], 1'b1};
    w_full      = r_neg ? ({(2*XLEN){1'b0}} - r_prod) : r_prod;
    w_qr        = r_f3[1] ? r_prod[2*XLEN-1:XLEN] : r_prod[XLEN-1:0];
    w_qr_signed = r_neg ? (c_ZERO - w_qr) : w_qr;
    if (r_f3[2]) begin
      w_result = w_qr_signed;
    end else if (r_f3[1:0] == 2'b00) begin
      w_result = w_full[XLEN-1:0];
    end else begin
      w_result = w_full[2*XLEN-1:XLEN];
    end
  end

  // Next-state selection; flush always returns to IDLE
  always_comb begin
    w_next = r_state;
    if (flush) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_fast)          w_next = S_FIN;
            else if (funct3[2])  w_next = S_DIV;
            else                 w_next = S_MUL;
          end
        end
        S_MUL:   if (r_cnt == c_LAST_ITER) w_next = S_FIN;
        S_DIV:   if (r_cnt == c_LAST_ITER) w_next = S_FIN;
        S_FIN:   w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Operand latching, iteration datapath and result beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_f3        <= 3'b000;
      r_rd        <= 5'd0;
      r_b         <= c_ZERO;
      r_neg       <= 1'b0;
      r_cnt       <= {CNT_W{1'b0}};
      r_prod      <= {(2*XLEN){1'b0}};
      r_busy      <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_data  <= c_ZERO;
      r_res_rd    <= 5'd0;
    end else begin
      r_res_valid <= 1'b0;
      if (flush) begin
        r_busy <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_accept) begin
              r_f3   <= funct3;
              r_rd   <= rd_addr;
              r_b    <= w_mag_b;
              r_cnt  <= {CNT_W{1'b0}};
              r_busy <= 1'b1;
              if (w_div_zero) begin
                // quotient all ones, remainder is the raw dividend
                r_prod <= {rs1_data, c_ALL_ONES};
                r_neg  <= 1'b0;
              end else if (w_div_ovf) begin
                // quotient is the most negative value, remainder zero
                r_prod <= {c_ZERO, c_MIN_INT};
                r_neg  <= 1'b0;
              end else begin
                r_prod <= {c_ZERO, w_mag_a};
                r_neg  <= w_neg;
              end
            end
          end
          S_MUL: begin
            r_prod <= w_mul_step;
            r_cnt  <= r_cnt + 1'b1;
          end
          S_DIV: begin
            r_prod <= w_div_step;
            r_cnt  <= r_cnt + 1'b1;
          end
          S_FIN: begin
            r_res_data  <= w_result;
            r_res_rd    <= r_rd;
            r_res_valid <= 1'b1;
            r_busy      <= 1'b0;
          end
          default: r_busy <= 1'b0;
        endcase
      end
    end
  end

  assign busy      = r_busy;
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_rd    = r_res_rd;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_muldiv_unit
//  Description : Self-checking bench for muldiv_unit: vector table, random
//                ops against a reference model, and hand-written sequences
//                for flush, reset, ignored start and back-to-back issue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [4:0]  rd_addr;
  logic        flush;
  logic        busy;
  logic        res_valid;
  logic [31:0] res_data;
  logic [4:0]  res_rd;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    bit          fast;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    int          at;
  } exp_t;

  exp_t sb_q[$];

  muldiv_unit #(.XLEN(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .funct3   (funct3),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .rd_addr  (rd_addr),
    .flush    (flush),
    .busy     (busy),
    .res_valid(res_valid),
    .res_data (res_data),
    .res_rd   (res_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // edge counter: value N after the Nth rising edge
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] ref_model(input logic [2:0] f3,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0]        p;
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic signed [31:0] sq;
    logic [31:0]        r;
    bit                 ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    r   = 32'h0;
    case (f3)
      3'd0: begin p = {32'h0, a} * {32'h0, b};             r = p[31:0];  end
      3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; r = p[63:32]; end
      3'd2: begin p = {{32{a[31]}}, a} * {32'h0, b};       r = p[63:32]; end
      3'd3: begin p = {32'h0, a} * {32'h0, b};             r = p[63:32]; end
      3'd4: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (ovf) r = 32'h8000_0000;
        else begin sq = sa / sb; r = sq; end
      end
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) r = a;
        else if (ovf) r = 32'h0;
        else begin sq = sa % sb; r = sq; end
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic bit is_fast(input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] b);
    return f3[2] && ((b == 0) ||
           (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // wait (bounded) until the monitor has consumed every expected result
  task automatic drain(input int budget);
    for (int i = 0; i < budget && sb_q.size() != 0; i++) @(negedge clk);
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL result_timeout: actual=%0d pending results required=0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic run_op(input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp, input bit fast);
    exp_t e;
    @(negedge clk);
    start = 1'b1; funct3 = f3; rs1_data = a; rs2_data = b; rd_addr = rd;
    @(posedge clk);
    #1;
    e.data = exp; e.rd = rd; e.at = cyc + (fast ? 1 : 33);
    sb_q.push_back(e);
    chk("busy_after_accept", {31'h0, busy}, 32'h1);
    start = 1'b0;
    rs1_data = ~a;
    rs2_data = ~b;
    drain(45);
  endtask

  initial begin
    vec_t        tbl[13];
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    exp_t        e;
    int          n;

    tbl[0]  = '{3'd0, 32'd7,         32'd6,         5'd5,  32'h0000_002A, 1'b0};
    tbl[1]  = '{3'd1, 32'hFFFF_FFFF, 32'd2,         5'd1,  32'hFFFF_FFFF, 1'b0};
    tbl[2]  = '{3'd3, 32'hFFFF_FFFF, 32'd2,         5'd2,  32'h0000_0001, 1'b0};
    tbl[3]  = '{3'd2, 32'hFFFF_FFFF, 32'd2,         5'd3,  32'hFFFF_FFFF, 1'b0};
    tbl[4]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,         5'd4,  32'hFFFF_FFFD, 1'b0};
    tbl[5]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,         5'd6,  32'hFFFF_FFFF, 1'b0};
    tbl[6]  = '{3'd5, 32'd100,       32'd7,         5'd7,  32'd14,        1'b0};
    tbl[7]  = '{3'd7, 32'd100,       32'd7,         5'd8,  32'd2,         1'b0};
    tbl[8]  = '{3'd5, 32'd5,         32'd0,         5'd9,  32'hFFFF_FFFF, 1'b1};
    tbl[9]  = '{3'd7, 32'd5,         32'd0,         5'd10, 32'd5,         1'b1};
    tbl[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1'b1};
    tbl[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0,  32'h0000_0000, 1'b1};
    tbl[12] = '{3'd1, 32'h8000_0000, 32'h8000_0000, 5'd31, 32'h4000_0000, 1'b0};

    rst_n = 1'b0; start = 1'b0; flush = 1'b0; funct3 = 3'd0;
    rs1_data = 32'h0; rs2_data = 32'h0; rd_addr = 5'd0;

    // scoreboard monitor: every result beat must match the head of the queue
    fork
      forever begin
        @(negedge clk);
        if (rst_n && res_valid) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: actual data=%h rd=%0d required no result", res_data, res_rd);
          end else begin
            e = sb_q.pop_front();
            chk("res_data", res_data, e.data);
            chk("res_rd", {27'h0, res_rd}, {27'h0, e.rd});
            chk("res_edge", cyc, e.at);
            chk("busy_at_result", {31'h0, busy}, 32'h0);
          end
        end
      end
    join_none

    #3;
    chk("reset_busy", {31'h0, busy}, 32'h0);
    chk("reset_valid", {31'h0, res_valid}, 32'h0);
    chk("reset_data", res_data, 32'h0);
    chk("reset_rd", {27'h0, res_rd}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++)
      run_op(tbl[i].f3, tbl[i].a, tbl[i].b, tbl[i].rd, tbl[i].exp, tbl[i].fast);

    // flush in the middle of a divide: no result, busy drops next edge
    @(negedge clk);
    start = 1'b1; funct3 = 3'd4; rs1_data = 32'd1000; rs2_data = 32'd3; rd_addr = 5'd12;
    @(posedge clk); #1; start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1;
    chk("flush_busy", {31'h0, busy}, 32'h0);
    flush = 1'b0;
    repeat (40) @(negedge clk);
    run_op(3'd0, 32'd3, 32'd3, 5'd3, 32'd9, 1'b0);

    // flush and start together: start is dropped
    @(negedge clk);
    start = 1'b1; flush = 1'b1; funct3 = 3'd0; rs1_data = 32'd2; rs2_data = 32'd2;
    @(posedge clk); #1;
    chk("flush_beats_start", {31'h0, busy}, 32'h0);
    start = 1'b0; flush = 1'b0;
    repeat (40) @(negedge clk);

    // asynchronous reset mid-multiply clears everything at once
    @(negedge clk);
    start = 1'b1; funct3 = 3'd0; rs1_data = 32'h1234; rs2_data = 32'h5678; rd_addr = 5'd14;
    @(posedge clk); #1; start = 1'b0;
    repeat (20) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("areset_busy", {31'h0, busy}, 32'h0);
    chk("areset_valid", {31'h0, res_valid}, 32'h0);
    chk("areset_data", res_data, 32'h0);
    chk("areset_rd", {27'h0, res_rd}, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    repeat (40) @(negedge clk);

    // start held through busy (ignored) then accepted on the result cycle
    @(negedge clk);
    start = 1'b1; funct3 = 3'd0; rs1_data = 32'd7; rs2_data = 32'd6; rd_addr = 5'd5;
    @(posedge clk); #1;
    n = cyc;
    e.data = 32'd42; e.rd = 5'd5;  e.at = n + 33;      sb_q.push_back(e);
    e.data = 32'd14; e.rd = 5'd17; e.at = n + 34 + 33; sb_q.push_back(e);
    funct3 = 3'd5; rs1_data = 32'd100; rs2_data = 32'd7; rd_addr = 5'd17;
    repeat (34) @(posedge clk);
    #1;
    chk("b2b_accept_busy", {31'h0, busy}, 32'h1);
    start = 1'b0; rs1_data = 32'h0; rs2_data = 32'h0;
    drain(45);

    // random ops against the reference model
    for (int i = 0; i < 10; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = (i % 4 == 3) ? 32'h0 : $urandom;
      if (i % 5 == 1) b = b >> 20;
      rd = 5'($urandom_range(0, 31));
      run_op(f3, a, b, rd, ref_model(f3, a, b), is_fast(f3, a, b));
    end

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
